// File: rtl/dynamic_lighting_pkg.sv
// rtl/dynamic_lighting_pkg.sv - scan states, board default ratio and index-width helper
package dynamic_lighting_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,  // after reset, nothing scanned yet
        ST_BLANK = 2'd1,  // anti-ghosting gap, all anodes off
        ST_SHOW  = 2'd2   // selected digit driven
    } scan_state_t;

    // 1 kHz scan strobe from the 40 MHz board clock
    localparam int DEFAULT_DIV_40MHZ = 40000;

    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/ce_prescaler.sv
// rtl/ce_prescaler.sv - runtime-loadable clock-enable divider with minimum-ratio clamp
//   clk, reset      : clock, asynchronous active-high reset
//   div_load        : load div_value as the new ratio and restart the count
//   div_value       : requested ratio (clk cycles per ce_out)
//   ce_out          : one-cycle strobe on the terminal count
module ce_prescaler #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 40000,
    parameter int MIN_DIV     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    output logic                 ce_out
);

    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(MIN_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] div;
    logic                 terminal;

    assign terminal = (count == div - ONE);
    // A load in the terminal cycle restarts the count, so that strobe is dropped.
    assign ce_out   = terminal && !div_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            div   <= DIV_RST;
        end else if (div_load) begin
            // Floor keeps the ratio long enough for the blank gap plus one shown cycle.
            div   <= (div_value < DIV_MIN) ? DIV_MIN : div_value;
            count <= '0;
        end else if (terminal) begin
            count <= '0;
        end else begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/dynamic_lighting_scanner.sv
// rtl/dynamic_lighting_scanner.sv - multiplexed 7-seg scanner with blanking, digit skip and frame flag
//   clk, reset      : clock, asynchronous active-high reset
//   div_load        : load div_value as scan prescaler ratio
//   div_value       : clk cycles per scan strobe
//   digit_en        : per-digit enable, bit i = digit i
//   seg_in          : segment data, digit i = seg_in[i*SEG_WIDTH +: SEG_WIDTH]
//   ce_out          : one-cycle scan strobe
//   anode           : digit drive, polarity from ANODE_ACTIVE_LOW
//   seg_out         : segments of the shown digit, 0 while blank
//   digit_idx       : currently selected digit
//   frame_end       : pulses with the strobe that wraps the scan
module dynamic_lighting_scanner
    import dynamic_lighting_pkg::*;
#(
    parameter int DIGITS           = 4,
    parameter int DIV_WIDTH        = 16,
    parameter int DEFAULT_DIV      = DEFAULT_DIV_40MHZ,
    parameter int BLANK_CYCLES     = 2,
    parameter int SEG_WIDTH        = 8,
    parameter int ANODE_ACTIVE_LOW = 1,
    localparam int IDX_W           = idx_width(DIGITS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        div_load,
    input  logic [DIV_WIDTH-1:0]        div_value,
    input  logic [DIGITS-1:0]           digit_en,
    input  logic [DIGITS*SEG_WIDTH-1:0] seg_in,
    output logic                        ce_out,
    output logic [DIGITS-1:0]           anode,
    output logic [SEG_WIDTH-1:0]        seg_out,
    output logic [IDX_W-1:0]            digit_idx,
    output logic                        frame_end
);

    localparam logic              ACT_LOW   = (ANODE_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] ANODE_OFF = {DIGITS{ACT_LOW}};
    localparam int                BCNT_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    scan_state_t       state, state_n;
    logic [BCNT_W-1:0] bcnt, bcnt_n;
    logic [IDX_W-1:0]  idx_n;
    logic [IDX_W-1:0]  nxt;
    logic [IDX_W-1:0]  cand;
    logic              found;
    logic              ce;

    ce_prescaler #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV),
        .MIN_DIV     (BLANK_CYCLES + 2)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .div_load  (div_load),
        .div_value (div_value),
        .ce_out    (ce)
    );

    assign ce_out = ce;

    // Circular search for the next enabled digit. Candidates run from the
    // current index + 1 round to the current index itself; out of WAIT the
    // base is DIGITS-1 so the search starts at digit 0. Walking k downwards
    // lets the nearest hit overwrite the farther ones.
    always_comb begin : search
        int base;
        found = 1'b0;
        nxt   = '0;
        cand  = '0;
        base  = (state == ST_WAIT) ? DIGITS - 1 : int'(digit_idx);
        for (int k = DIGITS; k >= 1; k--) begin
            cand = IDX_W'((base + k) % DIGITS);
            if (digit_en[cand]) begin
                found = 1'b1;
                nxt   = cand;
            end
        end
    end

    // Wrap means the search came back round to an index at or below the
    // current one; with a single enabled digit that is every strobe.
    assign frame_end = ce && (state != ST_WAIT) && found && (nxt <= digit_idx);

    always_comb begin : next_state
        state_n = state;
        bcnt_n  = bcnt;
        idx_n   = digit_idx;
        if (ce) begin
            bcnt_n  = '0;
            state_n = ST_BLANK;
            if (found) begin
                idx_n = nxt;
                if (BLANK_CYCLES == 0) begin
                    state_n = ST_SHOW;
                end
            end
        end else if (state == ST_BLANK) begin
            if (int'(bcnt) + 1 >= BLANK_CYCLES) begin
                state_n = ST_SHOW;
            end else begin
                bcnt_n = bcnt + BCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_WAIT;
            bcnt      <= '0;
            digit_idx <= '0;
        end else begin
            state     <= state_n;
            bcnt      <= bcnt_n;
            digit_idx <= idx_n;
        end
    end

    // Pins are registered from the next-state view so the old digit drops
    // one cycle after the strobe and the new one lights BLANK_CYCLES+1 after.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode   <= ANODE_OFF;
            seg_out <= '0;
        end else if (state_n == ST_SHOW && digit_en[idx_n]) begin
            anode   <= ANODE_OFF ^ (DIGITS'(1) << idx_n);
            seg_out <= seg_in[idx_n*SEG_WIDTH +: SEG_WIDTH];
        end else begin
            anode   <= ANODE_OFF;
            seg_out <= '0;
        end
    end

endmodule

// File: tb/tb_dynamic_lighting_scanner.sv
// tb/tb_dynamic_lighting_scanner.sv - self-checking bench for dynamic_lighting_scanner
module tb_dynamic_lighting_scanner;

    localparam int DIGITS  = 4;
    localparam int DEF_DIV = 40000;
    localparam int BLANK   = 2;
    localparam int MIN_DIV = BLANK + 2;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        div_load  = 1'b0;
    logic [15:0] div_value = 16'd0;
    logic [3:0]  digit_en  = 4'b1111;
    logic [31:0] seg_in    = 32'h4F5B3F06;
    logic        ce_out;
    logic        frame_end;
    logic [3:0]  anode;
    logic [7:0]  seg_out;
    logic [1:0]  digit_idx;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    dynamic_lighting_scanner #(
        .DIGITS           (DIGITS),
        .DIV_WIDTH        (16),
        .DEFAULT_DIV      (DEF_DIV),
        .BLANK_CYCLES     (BLANK),
        .SEG_WIDTH        (8),
        .ANODE_ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .div_load  (div_load),
        .div_value (div_value),
        .digit_en  (digit_en),
        .seg_in    (seg_in),
        .ce_out    (ce_out),
        .anode     (anode),
        .seg_out   (seg_out),
        .digit_idx (digit_idx),
        .frame_end (frame_end)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: elapsed-cycle prescaler, nearest-enabled-digit search,
    // and "lit once BLANK cycles have passed since the strobe".
    int         m_div = DEF_DIV, m_cnt = 0, m_sel = 0, m_age = 0, m_nxt, m_cand;
    bit         m_wait = 1'b1, m_in_rst = 1'b1, m_found, m_show;
    logic       m_ce, m_fe;
    logic [3:0] m_anode = 4'hF;
    logic [7:0] m_seg = 8'h00;

    always @(negedge clk) begin
        #2;
        if (reset) begin
            check("reset_outputs", {ce_out, frame_end, digit_idx, anode, seg_out},
                  {1'b0, 1'b0, 2'd0, 4'hF, 8'h00});
            m_in_rst = 1'b1;
        end else begin
            if (m_in_rst) begin
                m_div = DEF_DIV; m_cnt = 0; m_sel = 0; m_age = 0; m_wait = 1'b1;
                m_anode = 4'hF; m_seg = 8'h00; m_in_rst = 1'b0;
            end
            m_ce = !div_load && (m_cnt == m_div - 1);
            m_found = 1'b0;
            m_nxt = 0;
            for (int k = 0; k < DIGITS; k++) begin
                m_cand = m_wait ? k : (m_sel + 1 + k) % DIGITS;
                if (!m_found && digit_en[2'(m_cand)]) begin
                    m_found = 1'b1;
                    m_nxt = m_cand;
                end
            end
            m_fe = m_ce && !m_wait && m_found && (m_nxt <= m_sel);
            check("cycle", {ce_out, frame_end, digit_idx, anode, seg_out},
                  {m_ce, m_fe, 2'(m_sel), m_anode, m_seg});
            if (div_load) begin
                m_div = (int'(div_value) < MIN_DIV) ? MIN_DIV : int'(div_value);
                m_cnt = 0;
            end else begin
                m_cnt = (m_cnt == m_div - 1) ? 0 : m_cnt + 1;
            end
            if (m_ce) begin
                if (m_found) m_sel = m_nxt;
                m_wait = 1'b0;
                m_age = 0;
            end else if (m_age < 1000) begin
                m_age++;
            end
            m_show  = !m_wait && (m_age >= BLANK) && digit_en[2'(m_sel)];
            m_anode = m_show ? ~(4'b0001 << m_sel) : 4'hF;
            m_seg   = m_show ? seg_in[m_sel*8 +: 8] : 8'h00;
        end
    end

    // Called at +0 of a cycle; returns at +3 of the strobe cycle.
    task automatic wait_strobe(input int budget, output int t);
        bit hit = 1'b0;
        t = cyc;
        for (int i = 0; i < budget && !hit; i++) begin
            if (i != 0) @(negedge clk);
            #3;
            if (ce_out) begin
                hit = 1'b1;
                t = cyc;
            end
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL strobe_wait: got no ce_out in %0d cycles, expected a strobe", budget);
        end
    endtask

    // Called at +0; returns at +0 of the following cycle.
    task automatic load_div(input int v);
        div_value = 16'(v);
        div_load  = 1'b1;
        @(negedge clk);
        div_load  = 1'b0;
    endtask

    task automatic next3();
        @(negedge clk);
        #3;
    endtask

    function automatic logic [7:0] seq(input int a, input int b, input int c, input int d);
        return {2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    function automatic logic [3:0] fe4(input bit a, input bit b, input bit c, input bit d);
        return {d, c, b, a};
    endfunction

    typedef struct {
        int         div;
        logic [3:0] en;
        int         period;
        logic [7:0] idx_seq;
        logic [3:0] fe_seq;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int         ts, t2, rel, ix;
        logic [3:0] exp_an;

        tbl[0] = '{10, 4'b1111, 10, seq(1, 2, 3, 0), fe4(0, 0, 0, 1)};
        tbl[1] = '{10, 4'b0101, 10, seq(2, 0, 2, 0), fe4(0, 1, 0, 1)};
        tbl[2] = '{6,  4'b0001, 6,  seq(0, 0, 0, 0), fe4(1, 1, 1, 1)};
        tbl[3] = '{1,  4'b1000, 4,  seq(3, 3, 3, 3), fe4(0, 1, 1, 1)};
        tbl[4] = '{7,  4'b0000, 7,  seq(0, 0, 0, 0), fe4(0, 0, 0, 0)};
        tbl[5] = '{2,  4'b0110, 4,  seq(1, 2, 1, 2), fe4(0, 0, 1, 0)};
        tbl[6] = '{0,  4'b1010, 4,  seq(1, 3, 1, 3), fe4(0, 0, 1, 0)};

        // Reset release with the default ratio
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rel = cyc;
        wait_strobe(DEF_DIV + 10, ts);
        check("first_strobe_cycle", ts - rel + 1, DEF_DIV);
        next3();
        next3();
        check("anode_blank_40002", anode, 4'hF);
        next3();
        check("anode_on_40003", anode, 4'hE);

        // Table: park on digit 0, then apply ratio/enable and follow four strobes
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            digit_en = 4'b0001;
            load_div(tbl[n].div);
            wait_strobe(60, t2);
            @(negedge clk);
            digit_en = tbl[n].en;
            for (int j = 0; j < 4; j++) begin
                wait_strobe(60, ts);
                check("tbl_period", ts - t2, tbl[n].period);
                check("tbl_frame_end", frame_end, tbl[n].fe_seq[j]);
                t2 = ts;
                next3();
                check("tbl_idx", digit_idx, tbl[n].idx_seq[2*j +: 2]);
                check("tbl_anode_gap", anode, 4'hF);
                next3();
                next3();
                ix = int'(tbl[n].idx_seq[2*j +: 2]);
                exp_an = tbl[n].en[ix] ? ~(4'b0001 << ix) : 4'hF;
                check("tbl_anode_on", anode, exp_an);
                check("tbl_seg_blank", seg_out == 8'h00, !tbl[n].en[ix]);
                @(negedge clk);
            end
        end

        // Load coincident with terminal count suppresses that strobe
        digit_en = 4'b1111;
        load_div(10);
        wait_strobe(30, ts);
        repeat (10) @(negedge clk);
        div_value = 16'd10;
        div_load  = 1'b1;
        #3;
        check("load_wins_no_ce", ce_out, 1'b0);
        @(negedge clk);
        div_load = 1'b0;
        wait_strobe(30, t2);
        check("load_wins_next_strobe", t2 - ts, 20);

        // Live segment and enable changes while digit 2 is shown
        @(negedge clk);
        seg_in   = 32'h4F3F5B06;
        digit_en = 4'b0100;
        load_div(20);
        wait_strobe(40, ts);
        next3();
        next3();
        next3();
        check("d2_seg_before", seg_out, 8'h3F);
        check("d2_anode", anode, 4'b1011);
        @(negedge clk);
        seg_in[23:16] = 8'h06;
        next3();
        check("d2_seg_after", seg_out, 8'h06);
        @(negedge clk);
        digit_en = 4'b0000;
        #3;
        check("d2_anode_hold", anode, 4'b1011);
        next3();
        check("d2_anode_off", anode, 4'hF);

        // Randomised run against the model
        @(negedge clk);
        load_div(8);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) digit_en = 4'($urandom);
            if ($urandom_range(15) == 0) seg_in = $urandom;
            if ($urandom_range(63) == 0) begin
                div_value = 16'($urandom_range(24));
                div_load  = 1'b1;
            end else begin
                div_load  = 1'b0;
            end
            @(negedge clk);
        end
        div_load = 1'b0;

        // Asynchronous reset mid-SHOW, then restart from digit 0
        digit_en = 4'b0001;
        load_div(20);
        wait_strobe(40, ts);
        next3();
        next3();
        next3();
        check("pre_reset_show", anode, 4'hE);
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_anode", anode, 4'hF);
        check("async_reset_seg", seg_out, 8'h00);
        check("async_reset_ce", ce_out, 1'b0);
        digit_en = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rel = cyc;
        wait_strobe(DEF_DIV + 10, ts);
        check("restart_strobe_cycle", ts - rel + 1, DEF_DIV);
        next3();
        check("restart_idx", digit_idx, 2'd0);
        next3();
        next3();
        check("restart_anode", anode, 4'hE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
